access_sequencer: RTL and testbench



---
 rtl/access_pkg.sv | 61 ++++++
 rtl/attempt_limiter.sv | 42 ++++
 rtl/access_sequencer.sv | 144 ++++++++++++++
 tb/tb_access_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/access_pkg.sv
// Shared profile codes, permission codes, FSM states and the profile decoder
// for the access sequencer.
package access_pkg;

  localparam logic [2:0] PROF_ADMIN  = 3'b101;
  localparam logic [2:0] PROF_TESTER = 3'b011;
  localparam logic [2:0] PROF_USER   = 3'b001;
  localparam logic [2:0] PROF_GUEST  = 3'b110;

  localparam logic [2:0] GRANT_ADMIN  = 3'b101;
  localparam logic [2:0] GRANT_GUEST  = 3'b011;
  localparam logic [2:0] GRANT_TESTER = 3'b110;
  localparam logic [2:0] GRANT_USER   = 3'b100;

  // Ids double as PIN_TABLE slice indices.
  typedef enum logic [1:0] {
    ID_ADMIN  = 2'd0,
    ID_TESTER = 2'd1,
    ID_USER   = 2'd2,
    ID_GUEST  = 2'd3
  } profile_id_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_VERIFY,
    ST_LOCKOUT
  } state_e;

  typedef struct packed {
    logic        valid;
    profile_id_e id;
  } profile_dec_t;

  function automatic profile_dec_t decode_profile(input logic [2:0] code);
    profile_dec_t d;
    d.valid = 1'b1;
    d.id    = ID_GUEST;
    case (code)
      PROF_ADMIN:  d.id = ID_ADMIN;
      PROF_TESTER: d.id = ID_TESTER;
      PROF_USER:   d.id = ID_USER;
      PROF_GUEST:  d.id = ID_GUEST;
      default:     d.valid = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] grant_code(input profile_id_e id);
    logic [2:0] g;
    g = GRANT_GUEST;
    case (id)
      ID_ADMIN:  g = GRANT_ADMIN;
      ID_TESTER: g = GRANT_TESTER;
      ID_USER:   g = GRANT_USER;
      ID_GUEST:  g = GRANT_GUEST;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/attempt_limiter.sv
// Consecutive-failure counter and lockout timer. lock_active stays high while
// the lockout has further cycles to run beyond the current one.
module attempt_limiter #(
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fail_evt,
  input  logic success_evt,
  output logic lock_start,
  output logic lock_active
);

  localparam int TRW = $clog2(MAX_TRIES + 1);
  localparam int LW  = $clog2(LOCK_CYCLES + 1);

  logic [TRW-1:0] tries;
  logic [LW-1:0]  lcnt;
  logic           locking;

  // tries parks at MAX_TRIES for the whole lockout and marks it as running
  assign locking     = (tries == TRW'(MAX_TRIES));
  assign lock_start  = fail_evt && (tries == TRW'(MAX_TRIES - 1));
  assign lock_active = locking && (lcnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tries <= '0;
      lcnt  <= '0;
    end else if (locking) begin
      if (lcnt == '0) tries <= '0;
      else            lcnt  <= lcnt - 1'b1;
    end else if (success_evt) begin
      tries <= '0;
    end else if (fail_evt) begin
      tries <= tries + 1'b1;
      if (lock_start) lcnt <= LW'(LOCK_CYCLES - 1);
    end
  end

endmodule

// File: rtl/access_sequencer.sv
// Profile request / serial PIN sequencer issuing one-cycle grant or fail
// pulses, with attempt counting and lockout delegated to attempt_limiter.
module access_sequencer
  import access_pkg::*;
#(
  parameter int unsigned                PIN_DIGITS  = 4,
  parameter logic [16*PIN_DIGITS-1:0]   PIN_TABLE   = 64'h0000_3456_2345_1234,
  parameter int unsigned                MAX_TRIES   = 3,
  parameter int unsigned                LOCK_CYCLES = 16,
  parameter int unsigned                TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] profile_in,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       cancel,
  output logic       grant_valid,
  output logic [2:0] grant,
  output logic       fail,
  output logic       busy,
  output logic       locked
);

  localparam int DW = $clog2(PIN_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e         state, state_nx;
  profile_id_e    id_q, id_nx;
  logic [DW-1:0]  dcnt, dcnt_nx;
  logic [TW-1:0]  tcnt, tcnt_nx;
  logic           mism, mism_nx;
  logic           gv_nx, fail_nx;
  logic [2:0]     grant_nx;
  logic           fail_evt, success_evt, lock_start, lock_active;
  profile_dec_t   dec;
  logic [31:0]    pin_off;
  logic [3:0]     exp_digit;

  attempt_limiter #(
    .MAX_TRIES  (MAX_TRIES),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_limiter (
    .clk        (clk),
    .rst_n      (rst_n),
    .fail_evt   (fail_evt),
    .success_evt(success_evt),
    .lock_start (lock_start),
    .lock_active(lock_active)
  );

  always_comb begin
    state_nx    = state;
    id_nx       = id_q;
    dcnt_nx     = dcnt;
    tcnt_nx     = tcnt;
    mism_nx     = mism;
    gv_nx       = 1'b0;
    grant_nx    = '0;
    fail_nx     = 1'b0;
    fail_evt    = 1'b0;
    success_evt = 1'b0;
    dec         = decode_profile(profile_in);
    // Digit 0 of an entry is the most significant nibble of the id's slice
    pin_off     = 32'(id_q) * (16 * PIN_DIGITS / 4) + 4 * (PIN_DIGITS - 1) - 4 * 32'(dcnt);
    exp_digit   = 4'(PIN_TABLE >> pin_off);

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (!dec.valid) begin
            fail_nx = 1'b1;
          end else begin
            id_nx    = dec.id;
            dcnt_nx  = '0;
            tcnt_nx  = '0;
            mism_nx  = 1'b0;
            state_nx = (dec.id == ID_GUEST) ? ST_VERIFY : ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (cancel) begin
          state_nx = ST_IDLE;
        end else if (digit_valid) begin
          if (digit != exp_digit) mism_nx = 1'b1;
          tcnt_nx = '0;
          dcnt_nx = dcnt + 1'b1;
          if (dcnt == DW'(PIN_DIGITS - 1)) state_nx = ST_VERIFY;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          fail_nx  = 1'b1;
          fail_evt = 1'b1;
          state_nx = lock_start ? ST_LOCKOUT : ST_IDLE;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      ST_VERIFY: begin
        if (!mism) begin
          gv_nx       = 1'b1;
          grant_nx    = grant_code(id_q);
          success_evt = 1'b1;
          state_nx    = ST_IDLE;
        end else begin
          fail_nx  = 1'b1;
          fail_evt = 1'b1;
          state_nx = lock_start ? ST_LOCKOUT : ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (!lock_active) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      id_q        <= ID_ADMIN;
      dcnt        <= '0;
      tcnt        <= '0;
      mism        <= 1'b0;
      grant_valid <= 1'b0;
      grant       <= '0;
      fail        <= 1'b0;
      busy        <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_nx;
      id_q        <= id_nx;
      dcnt        <= dcnt_nx;
      tcnt        <= tcnt_nx;
      mism        <= mism_nx;
      grant_valid <= gv_nx;
      grant       <= grant_nx;
      fail        <= fail_nx;
      busy        <= (state_nx != ST_IDLE);
      locked      <= (state_nx == ST_LOCKOUT);
    end
  end

endmodule

// File: tb/tb_access_sequencer.sv
// Randomized bench for access_sequencer: an entry-level behavioural model
// predicts every output each cycle; directed scenarios pin literal values.
module tb_access_sequencer;

  localparam int PIN_DIGITS  = 4;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 16;
  localparam int TIMEOUT     = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] profile_in = 3'b000;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'h0;
  logic       cancel = 1'b0;
  logic       grant_valid, fail, busy, locked;
  logic [2:0] grant;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  access_sequencer #(
    .PIN_DIGITS (PIN_DIGITS),
    .PIN_TABLE  (64'h0000_3456_2345_1234),
    .MAX_TRIES  (MAX_TRIES),
    .LOCK_CYCLES(LOCK_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .profile_in (profile_in),
    .digit_valid(digit_valid),
    .digit      (digit),
    .cancel     (cancel),
    .grant_valid(grant_valid),
    .grant      (grant),
    .fail       (fail),
    .busy       (busy),
    .locked     (locked)
  );

  // ---------------- reference model ----------------
  function automatic int ref_decode(input logic [2:0] p);
    case (p)
      3'b101:  return 0;
      3'b011:  return 1;
      3'b001:  return 2;
      3'b110:  return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int ref_pin(input int id);
    case (id)
      0:       return 'h1234;
      1:       return 'h2345;
      2:       return 'h3456;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_grant(input int id);
    case (id)
      0:       return 5;
      1:       return 6;
      2:       return 4;
      default: return 3;
    endcase
  endfunction

  bit         live = 0;
  int         m_tries = 0, m_lock = 0, m_idle = 0, m_id = 0, m_val = 0, m_cnt = 0;
  bit         m_coll = 0, m_vpend = 0, m_ok = 0;
  bit         e_gv = 0, e_fail = 0, e_busy = 0, e_locked = 0;
  logic [2:0] e_grant = 3'b000;

  task automatic model_fail();
    e_fail = 1;
    m_tries++;
    if (m_tries == MAX_TRIES) m_lock = LOCK_CYCLES;
  endtask

  task automatic model_step();
    e_gv = 0; e_grant = 3'b000; e_fail = 0;
    if (!rst_n) begin
      live = 1; m_tries = 0; m_lock = 0; m_coll = 0; m_vpend = 0;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_tries = 0;
    end else if (m_vpend) begin
      m_vpend = 0;
      if (m_ok) begin
        e_gv = 1; e_grant = 3'(ref_grant(m_id)); m_tries = 0;
      end else model_fail();
    end else if (m_coll) begin
      if (cancel) m_coll = 0;
      else if (digit_valid) begin
        m_val = (m_val << 4) | int'(digit);
        m_cnt++;
        m_idle = 0;
        if (m_cnt == PIN_DIGITS) begin
          m_coll = 0; m_vpend = 1; m_ok = (m_val == ref_pin(m_id));
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin m_coll = 0; model_fail(); end
      end
    end else if (start) begin
      m_id = ref_decode(profile_in);
      if (m_id < 0) e_fail = 1;
      else if (m_id == 3) begin m_vpend = 1; m_ok = 1; end
      else begin m_coll = 1; m_val = 0; m_cnt = 0; m_idle = 0; end
    end
    e_locked = (m_lock > 0);
    e_busy   = e_locked || m_vpend || m_coll;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (live) begin
      chk("m_grant_valid", 32'(grant_valid), 32'(e_gv));
      chk("m_grant",       32'(grant),       32'(e_grant));
      chk("m_fail",        32'(fail),        32'(e_fail));
      chk("m_busy",        32'(busy),        32'(e_busy));
      chk("m_locked",      32'(locked),      32'(e_locked));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] p);
    start = 1'b1; profile_in = p; step(); start = 1'b0;
  endtask

  task automatic do_digit(input logic [3:0] d);
    digit_valid = 1'b1; digit = d; step(); digit_valid = 1'b0;
  endtask

  task automatic entry(input logic [2:0] p, input logic [15:0] pin);
    do_start(p);
    for (int i = PIN_DIGITS - 1; i >= 0; i--) do_digit(pin[4*i +: 4]);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_gv"},     32'(grant_valid), 0);
    chk({name, "_grant"},  32'(grant),       0);
    chk({name, "_fail"},   32'(fail),        0);
    chk({name, "_busy"},   32'(busy),        0);
    chk({name, "_locked"}, 32'(locked),      0);
  endtask

  initial begin
    logic [2:0] pick [5];
    pick[0] = 3'b101; pick[1] = 3'b011; pick[2] = 3'b001; pick[3] = 3'b110; pick[4] = 3'b000;

    step(); step();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // ADMIN 1234
    do_start(3'b101);
    chk("admin_busy", 32'(busy), 1);
    for (int i = 1; i <= 4; i++) do_digit(4'(i));
    chk("admin_verify_gv", 32'(grant_valid), 0);
    step();
    chk("admin_gv", 32'(grant_valid), 1);
    chk("admin_grant", 32'(grant), 32'h5);
    chk("admin_idle", 32'(busy), 0);
    step();
    chk("admin_pulse_len", 32'(grant_valid), 0);

    // GUEST, digit ignored
    do_start(3'b110);
    chk("guest_busy", 32'(busy), 1);
    chk("guest_early", 32'(grant_valid), 0);
    digit_valid = 1'b1; digit = 4'h7; step(); digit_valid = 1'b0;
    chk("guest_gv", 32'(grant_valid), 1);
    chk("guest_grant", 32'(grant), 32'h3);

    // invalid profile
    do_start(3'b111);
    chk("inv_fail", 32'(fail), 1);
    chk("inv_busy", 32'(busy), 0);
    step();
    chk("inv_fail_len", 32'(fail), 0);

    // three wrong USER entries -> lockout
    for (int k = 0; k < 3; k++) begin
      entry(3'b001, 16'h3457);
      step();
      chk("wrong_fail", 32'(fail), 1);
      chk("wrong_locked", 32'(locked), 32'(k == 2));
    end
    for (int j = 1; j < LOCK_CYCLES; j++) begin
      if (j == 5) begin start = 1'b1; profile_in = 3'b101; end
      step();
      start = 1'b0;
      chk("lock_hold", 32'(locked), 1);
    end
    step();
    chk("lock_end", 32'(locked), 0);
    chk("lock_end_busy", 32'(busy), 0);
    entry(3'b001, 16'h3456);
    step();
    chk("after_lock_gv", 32'(grant_valid), 1);
    chk("after_lock_grant", 32'(grant), 32'h4);

    // TESTER timeout, then tries=1 shown by lock on the second wrong entry
    do_start(3'b011); do_digit(4'h2); do_digit(4'h3);
    repeat (TIMEOUT - 1) step();
    chk("to_early", 32'(fail), 0);
    chk("to_busy", 32'(busy), 1);
    step();
    chk("to_fail", 32'(fail), 1);
    chk("to_idle", 32'(busy), 0);
    entry(3'b001, 16'h9999); step();
    chk("to_try2_locked", 32'(locked), 0);
    entry(3'b001, 16'h9999); step();
    chk("to_try3_locked", 32'(locked), 1);
    repeat (LOCK_CYCLES) step();
    chk("to_lock_end", 32'(locked), 0);

    // cancel beats a same-cycle digit
    do_start(3'b011); do_digit(4'h2);
    cancel = 1'b1; digit_valid = 1'b1; digit = 4'h3; step();
    cancel = 1'b0; digit_valid = 1'b0;
    chk("cancel_busy", 32'(busy), 0);
    chk("cancel_fail", 32'(fail), 0);
    step();
    chk("cancel_nopulse", 32'(fail | grant_valid), 0);

    // reset after the third digit
    do_start(3'b001); do_digit(4'h3); do_digit(4'h4); do_digit(4'h5);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk_all_zero("midrst");
    entry(3'b001, 16'h3456); step();
    chk("midrst_gv", 32'(grant_valid), 1);
    chk("midrst_grant", 32'(grant), 32'h4);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      int r, id, nd, gap;
      logic [2:0] p;
      logic [3:0] d;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        rst_n = 1'b0; step(); rst_n = 1'b1;
      end else begin
        p  = (r < 12) ? 3'($urandom_range(0, 7)) : pick[$urandom_range(0, 4)];
        id = ref_decode(p);
        do_start(p);
        nd = int'($urandom_range(0, PIN_DIGITS));
        for (int i = 0; i < nd; i++) begin
          gap = ($urandom_range(0, 29) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 2));
          repeat (gap) step();
          if ($urandom_range(0, 19) == 0) cancel = 1'b1;
          if (id >= 0 && id <= 2 && $urandom_range(0, 3) != 0)
            d = 4'((ref_pin(id) >> (4 * (PIN_DIGITS - 1 - i))) & 15);
          else
            d = 4'($urandom_range(0, 15));
          do_digit(d);
          cancel = 1'b0;
        end
        repeat ($urandom_range(0, 3)) step();
      end
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
